// File: rtl/tthbif_path_cal.sv
// rtl/tthbif_path_cal.sv - delay-path calibration master
// Probes a delay path NUM_TRIALS times and reports a consistent round-trip latency or an error.
module tthbif_path_cal #(
  parameter int MAX_LAT    = 16,
  parameter int NUM_TRIALS = 4,
  localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             echo_i,
  output logic             probe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [LAT_W-1:0] lat_o
);

  localparam int QC_W = LAT_W + 1;
  localparam int TC_W = LAT_W + 3;
  localparam int TR_W = $clog2(NUM_TRIALS + 1);

  localparam logic [QC_W-1:0]  QUIET_LEN = QC_W'(MAX_LAT + 1);
  localparam logic [TC_W-1:0]  STUCK_LEN = TC_W'(4 * (MAX_LAT + 1));
  localparam logic [LAT_W-1:0] MAX_D     = LAT_W'(MAX_LAT);
  localparam logic [TR_W-1:0]  TRIALS    = TR_W'(NUM_TRIALS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_QUIET = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_STUCK    = 2'd3;

  logic [2:0]       r_state;
  logic [QC_W-1:0]  r_qcnt;
  logic [TC_W-1:0]  r_tcnt;
  logic [LAT_W-1:0] r_dcnt;
  logic [TR_W-1:0]  r_trial;
  logic [LAT_W-1:0] r_lat;
  logic [1:0]       r_status;
  logic             r_probe;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state_nxt;
  logic [QC_W-1:0]  w_qcnt_nxt;
  logic [TC_W-1:0]  w_tcnt_nxt;
  logic [LAT_W-1:0] w_dcnt_nxt;
  logic [TR_W-1:0]  w_trial_nxt;
  logic [LAT_W-1:0] w_lat_nxt;
  logic [1:0]       w_status_nxt;
  logic             w_trial_done;
  logic [LAT_W-1:0] w_trial_lat;

  always_comb begin
    w_state_nxt  = r_state;
    w_qcnt_nxt   = r_qcnt;
    w_tcnt_nxt   = r_tcnt;
    w_dcnt_nxt   = r_dcnt;
    w_trial_nxt  = r_trial;
    w_lat_nxt    = r_lat;
    w_status_nxt = r_status;
    w_trial_done = 1'b0;
    w_trial_lat  = '0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt  = S_QUIET;
          w_qcnt_nxt   = '0;
          w_tcnt_nxt   = '0;
          w_trial_nxt  = '0;
          w_lat_nxt    = '0;
          w_status_nxt = ST_OK;
        end
      end

      // A completed flush wins over the stuck limit when both land on the same cycle.
      S_QUIET: begin
        w_qcnt_nxt = echo_i ? '0 : r_qcnt + 1'b1;
        w_tcnt_nxt = r_tcnt + 1'b1;
        if (w_qcnt_nxt == QUIET_LEN) begin
          w_state_nxt = S_PULSE;
        end else if (w_tcnt_nxt == STUCK_LEN) begin
          w_status_nxt = ST_STUCK;
          w_state_nxt  = S_DONE;
        end
      end

      S_PULSE: begin
        w_dcnt_nxt = LAT_W'(1);
        if (echo_i) begin
          w_trial_done = 1'b1;
          w_trial_lat  = '0;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (echo_i) begin
          w_trial_done = 1'b1;
          w_trial_lat  = r_dcnt;
        end else if (r_dcnt == MAX_D) begin
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = S_DONE;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end

      S_DONE: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase

    // The first trial sets the reference; later trials must reproduce it exactly.
    if (w_trial_done) begin
      w_trial_nxt = r_trial + 1'b1;
      if (r_trial == '0) begin
        w_lat_nxt = w_trial_lat;
      end
      if ((r_trial != '0) && (w_trial_lat != r_lat)) begin
        w_status_nxt = ST_MISMATCH;
        w_state_nxt  = S_DONE;
      end else if (w_trial_nxt == TRIALS) begin
        w_status_nxt = ST_OK;
        w_state_nxt  = S_DONE;
      end else begin
        w_state_nxt = S_QUIET;
        w_qcnt_nxt  = '0;
        w_tcnt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_qcnt   <= '0;
      r_tcnt   <= '0;
      r_dcnt   <= '0;
      r_trial  <= '0;
      r_lat    <= '0;
      r_status <= ST_OK;
      r_probe  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_trial  <= w_trial_nxt;
      r_lat    <= w_lat_nxt;
      r_status <= w_status_nxt;
      r_probe  <= (w_state_nxt == S_PULSE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign probe_o  = r_probe;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign status_o = r_status;
  assign lat_o    = r_lat;

endmodule

// File: tb/tb_tthbif_path_cal.sv
// tb/tb_tthbif_path_cal.sv - directed bench for tthbif_path_cal
// Drives the calibrator against a flop-path model, a wire, and stuck echo levels.
module tb_tthbif_path_cal;

  localparam int MAX_LAT    = 16;
  localparam int NUM_TRIALS = 4;
  localparam int LAT_W      = $clog2(MAX_LAT + 1);
  localparam int NUM_TAP    = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             echo;
  logic             probe;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [LAT_W-1:0] lat;

  logic [NUM_TAP-1:0] r_sr;
  int                 tap;
  int                 mode;

  int cyc;
  int probe_n;
  int probe_cyc [8];
  int done_n;
  int done_cyc;
  int done_busy;
  int busy_rise;
  logic busy_q;

  int n_checks;
  int n_fail;

  tthbif_path_cal #(.MAX_LAT(MAX_LAT), .NUM_TRIALS(NUM_TRIALS)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .echo_i   (echo),
    .probe_o  (probe),
    .busy_o   (busy),
    .done_o   (done),
    .status_o (status),
    .lat_o    (lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tap k delays the probe by k+1 cycles.
  always @(posedge clk) r_sr <= {r_sr[NUM_TAP-2:0], probe};

  always_comb begin
    case (mode)
      0:       echo = r_sr[tap];
      1:       echo = probe;
      2:       echo = 1'b0;
      default: echo = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (probe) begin
      if (probe_n < 8) probe_cyc[probe_n] = cyc;
      probe_n = probe_n + 1;
    end
    if (done) begin
      done_cyc  = cyc;
      done_busy = int'(busy);
      done_n    = done_n + 1;
    end
    if (busy && !busy_q) busy_rise = cyc;
    busy_q = busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    probe_n = 0;
    done_n  = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_n == 0) check_eq({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_probes(input int cnt, input int budget);
    int n;
    n = 0;
    while (probe_n < cnt && n < budget) begin
      step();
      n++;
    end
    if (probe_n < cnt) check_eq("probe_wait_timeout", probe_n, cnt);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_probe"},  probe,  0);
    check_eq({tag, "_busy"},   busy,   0);
    check_eq({tag, "_done"},   done,   0);
    check_eq({tag, "_status"}, status, 0);
    check_eq({tag, "_lat"},    lat,    0);
  endtask

  initial begin
    int t0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    busy_q   = 1'b0;
    busy_rise = 0;
    done_cyc = 0;
    done_busy = 0;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2;
    tap      = 3;
    clear_logs();
    repeat (3) step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();

    // Flop path, tap 3: latency 4 on every trial.
    mode = 0; tap = 3;
    clear_logs();
    pulse_start();
    check_eq("flop_busy_after_start", busy, 1);
    wait_done("flop", 400);
    check_eq("flop_probes", probe_n, 4);
    check_eq("flop_status", status, 0);
    check_eq("flop_lat", lat, 4);
    check_eq("flop_spacing", probe_cyc[1] - probe_cyc[0], 22);
    check_eq("flop_spacing_last", probe_cyc[3] - probe_cyc[2], 22);
    check_eq("flop_done_after_echo", done_cyc - probe_cyc[3], 5);
    check_eq("flop_busy_in_done", done_busy, 1);
    step();
    check_eq("flop_busy_after_done", busy, 0);
    check_eq("flop_done_single", done, 0);
    repeat (5) step();
    check_eq("flop_lat_held", lat, 4);
    check_eq("flop_done_count", done_n, 1);

    // Direct wire: combinational loopback gives latency 0.
    mode = 1;
    clear_logs();
    pulse_start();
    wait_done("wire", 400);
    check_eq("wire_probes", probe_n, 4);
    check_eq("wire_status", status, 0);
    check_eq("wire_lat", lat, 0);
    check_eq("wire_spacing", probe_cyc[1] - probe_cyc[0], 18);
    step();

    // Echo tied low: one probe, then timeout.
    mode = 2;
    clear_logs();
    pulse_start();
    wait_done("low", 400);
    check_eq("low_probes", probe_n, 1);
    check_eq("low_status", status, 1);
    check_eq("low_lat", lat, 0);
    check_eq("low_done_delay", done_cyc - probe_cyc[0], 17);
    step();

    // Echo tied high: the flush never completes.
    mode = 3;
    clear_logs();
    pulse_start();
    wait_done("high", 400);
    check_eq("high_probes", probe_n, 0);
    check_eq("high_status", status, 3);
    check_eq("high_lat", lat, 0);
    check_eq("high_done_delay", done_cyc - busy_rise, 68);
    step();

    // Tap moved from 2 to 5 after trial 1's echo.
    mode = 0; tap = 2;
    clear_logs();
    pulse_start();
    wait_probes(1, 200);
    t0 = probe_cyc[0];
    while (cyc < t0 + 5) step();
    tap = 5;
    wait_done("mis", 400);
    check_eq("mis_status", status, 2);
    check_eq("mis_lat", lat, 3);
    check_eq("mis_probes", probe_n, 2);
    step();

    // Reset while waiting for trial 2's echo.
    tap = 3;
    repeat (10) step();
    clear_logs();
    pulse_start();
    wait_probes(2, 200);
    step();
    rst = 1'b1;
    step();
    check_idle_zero("rst_mid");
    check_eq("rst_mid_no_done", done_n, 0);
    rst = 1'b0;
    repeat (30) step();
    check_eq("rst_mid_stays_idle", busy, 0);
    check_eq("rst_mid_probes", probe_n, 2);
    check_eq("rst_mid_done_later", done_n, 0);

    // Start while busy is ignored; a later start runs a full calibration.
    clear_logs();
    pulse_start();
    wait_probes(1, 200);
    repeat (3) step();
    pulse_start();
    wait_done("ign", 400);
    check_eq("ign_probes", probe_n, 4);
    check_eq("ign_status", status, 0);
    repeat (5) step();
    check_eq("ign_done_count", done_n, 1);
    clear_logs();
    pulse_start();
    wait_done("again", 400);
    check_eq("again_probes", probe_n, 4);
    check_eq("again_status", status, 0);
    check_eq("again_lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
